// File: rtl/wb_decoder_pkg.sv
// wb_decoder_pkg: bus widths and decoder FSM state encoding
package wb_decoder_pkg;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/wb_decoder_if.sv
// wb_decoder_if: host Wishbone port plus per-slave strobe/data/ack fan-out
interface wb_decoder_if #(parameter int NUM_SLAVES = 4);
  import wb_decoder_pkg::*;
  logic [WB_AW-1:0] wb_addr;
  logic wb_cyc;
  logic wb_strobe;
  logic wb_we;
  logic [WB_DW-1:0] wb_data;
  logic wb_ack;
  logic wb_err;
  logic [NUM_SLAVES-1:0] s_strobe;
  logic [NUM_SLAVES-1:0] s_ack;
  logic [NUM_SLAVES-1:0][WB_DW-1:0] s_data;
  modport master (
    output wb_addr, wb_cyc, wb_strobe, wb_we, s_data, s_ack,
    input  wb_data, wb_ack, wb_err, s_strobe
  );
  modport slave (
    input  wb_addr, wb_cyc, wb_strobe, wb_we, s_data, s_ack,
    output wb_data, wb_ack, wb_err, s_strobe
  );
endinterface

// File: rtl/wb_decoder_timeout.sv
// wb_decoder_timeout: saturating cycle counter flagging the last allowed cycle
module wb_decoder_timeout #(parameter int TIMEOUT = 16) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] tcnt;
  always_ff @(posedge clock)
    if (reset || load) tcnt <= '0;
    else if (enable && tcnt != W'(TIMEOUT)) tcnt <= tcnt + 1'b1;
  assign expired = TIMEOUT != 0 && tcnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/wb_decoder.sv
// wb_decoder: registered Wishbone classic slot decoder with error termination
module wb_decoder
  import wb_decoder_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB = 16,
  parameter int SEL_W = 2,
  parameter int TIMEOUT = 16
) (
  input logic clock,
  input logic reset,
  wb_decoder_if.slave bus
);
  state_t state, state_nx;
  logic [SEL_W-1:0] sel, slot;
  logic req, hit, sel_ack, expired, do_ack, do_err;
  assign req = bus.wb_cyc && bus.wb_strobe;
  assign slot = bus.wb_addr[SEL_LSB +: SEL_W];
  assign hit = int'(slot) < NUM_SLAVES;
  assign sel_ack = bus.s_ack[sel];
  assign bus.s_strobe = (state == ACTIVE && req) ? NUM_SLAVES'(1) << sel : '0;
  wb_decoder_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock(clock),
    .reset(reset),
    .load(state != ACTIVE),
    .enable(state == ACTIVE),
    .expired(expired)
  );
  always_comb begin
    state_nx = state;
    do_ack = 1'b0;
    do_err = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_nx = hit ? ACTIVE : DONE;
        do_err = !hit;
      end
      // master abort wins over a same-cycle ack or timeout
      ACTIVE: if (!bus.wb_cyc) state_nx = IDLE;
        else if (sel_ack || expired) begin
          state_nx = DONE;
          do_ack = sel_ack;
          do_err = !sel_ack;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      bus.wb_ack <= 1'b0;
      bus.wb_err <= 1'b0;
      bus.wb_data <= '0;
    end else begin
      state <= state_nx;
      bus.wb_ack <= do_ack;
      bus.wb_err <= do_err;
      if (do_ack || do_err) bus.wb_data <= do_ack ? bus.s_data[sel] : '0;
      if (state == IDLE && req && hit) sel <= slot;
    end
endmodule

// File: tb/tb_wb_decoder.sv
// tb_wb_decoder: scoreboard bench for the registered Wishbone slot decoder
module tb_wb_decoder;
  import wb_decoder_pkg::*;
  typedef struct packed { logic err; logic [WB_DW-1:0] data; } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t e;
  int n;
  always #5 clock = ~clock;
  wb_decoder_if #(.NUM_SLAVES(4)) bus();
  wb_decoder_if #(.NUM_SLAVES(3)) bus3();
  wb_decoder #(.NUM_SLAVES(4), .SEL_LSB(16), .SEL_W(2), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  wb_decoder #(.NUM_SLAVES(3), .SEL_LSB(16), .SEL_W(2), .TIMEOUT(16)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3)
  );

  task automatic wait_term(input int max, output int cyc);
    cyc = -1;
    for (int i = 0; i < max && cyc < 0; i++) begin
      @(negedge clock);
      if (bus.wb_ack || bus.wb_err) cyc = i;
    end
  endtask

  task automatic drop();
    bus.wb_cyc = 1'b0;
    bus.wb_strobe = 1'b0;
    bus.s_ack = '0;
    bus3.wb_cyc = 1'b0;
    bus3.wb_strobe = 1'b0;
    bus3.s_ack = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wb_addr = 32'h0001_0000; bus.wb_cyc = 1'b1; bus.wb_strobe = 1'b1; bus.wb_we = 1'b0;
    bus.s_ack = '1; bus.s_data = '1;
    bus3.wb_addr = 32'h0001_0000; bus3.wb_cyc = 1'b1; bus3.wb_strobe = 1'b1; bus3.wb_we = 1'b0;
    bus3.s_ack = '1; bus3.s_data = '1;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.wb_ack, bus.wb_err, bus.wb_data, bus.s_strobe} !== '0) begin
      failures++;
      $display("FAIL reset4 got ack=%b err=%b data=%h stb=%b want all zero", bus.wb_ack, bus.wb_err, bus.wb_data, bus.s_strobe);
    end
    checks++;
    if ({bus3.wb_ack, bus3.wb_err, bus3.wb_data, bus3.s_strobe} !== '0) begin
      failures++;
      $display("FAIL reset3 got ack=%b err=%b data=%h stb=%b want all zero", bus3.wb_ack, bus3.wb_err, bus3.wb_data, bus3.s_strobe);
    end
    reset = 1'b0;
    drop();
    @(negedge clock);
  endtask

  task automatic test_read();
    bus.s_data = '0;
    bus.s_data[0] = 32'hDEAD_BEEF;
    bus.s_data[1] = 32'h0000_00A5;
    bus.wb_addr = 32'h0001_0004; bus.wb_cyc = 1'b1; bus.wb_strobe = 1'b1;
    exp_q.push_back('{err: 1'b0, data: 32'h0000_00A5});
    @(negedge clock);
    checks++;
    if ({bus.s_strobe, bus.wb_ack, bus.wb_err} !== {4'b0010, 2'b00}) begin
      failures++;
      $display("FAIL read_strobe got stb=%b ack=%b err=%b want stb=0010 ack=0 err=0", bus.s_strobe, bus.wb_ack, bus.wb_err);
    end
    repeat (2) @(negedge clock);
    bus.s_ack = 4'b0010;
    wait_term(4, n);
    e = exp_q.pop_front();
    checks++;
    if (n != 0 || {bus.wb_ack, bus.wb_err, bus.wb_data} !== {~e.err, e.err, e.data}) begin
      failures++;
      $display("FAIL read_term got n=%0d ack=%b err=%b data=%h want n=0 err=%b data=%h", n, bus.wb_ack, bus.wb_err, bus.wb_data, e.err, e.data);
    end
    drop();
    @(negedge clock);
    checks++;
    if ({bus.wb_ack, bus.wb_err, bus.wb_data} !== {2'b00, 32'h0000_00A5}) begin
      failures++;
      $display("FAIL read_hold got ack=%b err=%b data=%h want ack=0 err=0 data=000000a5", bus.wb_ack, bus.wb_err, bus.wb_data);
    end
  endtask

  task automatic test_unmapped();
    bus3.s_data = '0;
    bus3.s_data[2] = 32'h1234_5678;
    bus3.wb_addr = 32'h0002_0000; bus3.wb_cyc = 1'b1; bus3.wb_strobe = 1'b1;
    exp_q.push_back('{err: 1'b0, data: 32'h1234_5678});
    @(negedge clock);
    checks++;
    if (bus3.s_strobe !== 3'b100) begin
      failures++;
      $display("FAIL unmap_pre_strobe got %b want 100", bus3.s_strobe);
    end
    bus3.s_ack = 3'b100;
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({bus3.wb_ack, bus3.wb_err, bus3.wb_data} !== {~e.err, e.err, e.data}) begin
      failures++;
      $display("FAIL unmap_pre_term got ack=%b err=%b data=%h want err=%b data=%h", bus3.wb_ack, bus3.wb_err, bus3.wb_data, e.err, e.data);
    end
    drop();
    @(negedge clock);
    bus3.wb_addr = 32'h0003_0000; bus3.wb_cyc = 1'b1; bus3.wb_strobe = 1'b1;
    exp_q.push_back('{err: 1'b1, data: 32'h0});
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({bus3.s_strobe, bus3.wb_ack, bus3.wb_err, bus3.wb_data} !== {3'b000, ~e.err, e.err, e.data}) begin
      failures++;
      $display("FAIL unmap_err got stb=%b ack=%b err=%b data=%h want stb=000 err=%b data=%h", bus3.s_strobe, bus3.wb_ack, bus3.wb_err, bus3.wb_data, e.err, e.data);
    end
    drop();
    @(negedge clock);
    checks++;
    if ({bus3.wb_ack, bus3.wb_err, bus3.s_strobe} !== 5'b0) begin
      failures++;
      $display("FAIL unmap_pulse got ack=%b err=%b stb=%b want all zero", bus3.wb_ack, bus3.wb_err, bus3.s_strobe);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bus.wb_addr = 32'h0000_0000; bus.wb_cyc = 1'b1; bus.wb_strobe = 1'b1; bus.s_ack = '0;
    exp_q.push_back('{err: 1'b1, data: 32'h0});
    n = -1;
    for (int i = 0; i < 40 && n < 0; i++) begin
      @(negedge clock);
      if (bus.wb_ack || bus.wb_err) n = i;
      else if (bus.s_strobe == 4'b0001) cnt++;
    end
    e = exp_q.pop_front();
    checks++;
    if (n != 16 || cnt != 16 || {bus.wb_ack, bus.wb_err, bus.wb_data} !== {~e.err, e.err, e.data}) begin
      failures++;
      $display("FAIL timeout got n=%0d strobes=%0d ack=%b err=%b data=%h want n=16 strobes=16 err=1 data=0", n, cnt, bus.wb_ack, bus.wb_err, bus.wb_data);
    end
    drop();
    @(negedge clock);
    checks++;
    if ({bus.wb_ack, bus.wb_err, bus.s_strobe} !== 6'b0) begin
      failures++;
      $display("FAIL timeout_idle got ack=%b err=%b stb=%b want all zero", bus.wb_ack, bus.wb_err, bus.s_strobe);
    end
  endtask

  task automatic test_stray_ack();
    bus.s_data[0] = 32'h0000_0C3C;
    bus.s_data[2] = 32'hBAD0_0BAD;
    bus.wb_addr = 32'h0000_0000; bus.wb_cyc = 1'b1; bus.wb_strobe = 1'b1;
    exp_q.push_back('{err: 1'b0, data: 32'h0000_0C3C});
    @(negedge clock);
    bus.s_ack = 4'b0100;
    bus.wb_addr = 32'h0002_0000;
    @(negedge clock);
    checks++;
    if ({bus.s_strobe, bus.wb_ack, bus.wb_err} !== {4'b0001, 2'b00}) begin
      failures++;
      $display("FAIL stray_ignored got stb=%b ack=%b err=%b want stb=0001 ack=0 err=0", bus.s_strobe, bus.wb_ack, bus.wb_err);
    end
    bus.s_ack = 4'b0001;
    wait_term(3, n);
    e = exp_q.pop_front();
    checks++;
    if (n != 0 || {bus.wb_ack, bus.wb_err, bus.wb_data} !== {~e.err, e.err, e.data}) begin
      failures++;
      $display("FAIL stray_term got n=%0d ack=%b err=%b data=%h want n=0 err=%b data=%h", n, bus.wb_ack, bus.wb_err, bus.wb_data, e.err, e.data);
    end
    drop();
    @(negedge clock);
  endtask

  task automatic test_abort_reset();
    bus.wb_addr = 32'h0000_0000; bus.wb_cyc = 1'b1; bus.wb_strobe = 1'b1;
    @(negedge clock);
    bus.s_ack = 4'b0001;
    bus.wb_cyc = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.wb_ack, bus.wb_err, bus.s_strobe, bus.wb_data} !== {6'b0, 32'h0000_0C3C}) begin
      failures++;
      $display("FAIL abort got ack=%b err=%b stb=%b data=%h want ack=0 err=0 stb=0000 data=00000c3c", bus.wb_ack, bus.wb_err, bus.s_strobe, bus.wb_data);
    end
    bus.s_ack = '0;
    bus.wb_addr = 32'h0003_0000; bus.wb_cyc = 1'b1; bus.wb_strobe = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.s_strobe !== 4'b1000) begin
      failures++;
      $display("FAIL abort_restart got stb=%b want 1000", bus.s_strobe);
    end
    reset = 1'b1;
    bus.s_ack = 4'b1000;
    @(negedge clock);
    checks++;
    if ({bus.wb_ack, bus.wb_err, bus.wb_data, bus.s_strobe} !== '0) begin
      failures++;
      $display("FAIL mid_reset got ack=%b err=%b data=%h stb=%b want all zero", bus.wb_ack, bus.wb_err, bus.wb_data, bus.s_strobe);
    end
    reset = 1'b0;
    drop();
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int pulses = 0;
    int last = -1;
    bus.wb_addr = 32'h0001_0000; bus.wb_cyc = 1'b1; bus.wb_strobe = 1'b1; bus.wb_we = 1'b1;
    for (int c = 1; c <= 20 && pulses < 3; c++) begin
      @(negedge clock);
      if (bus.wb_ack || bus.wb_err) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.wb_ack, bus.wb_err, bus.wb_data} !== {1'b1, 1'b0, e.data} || (last >= 0 && c - last != 3)) begin
          failures++;
          $display("FAIL b2b_pulse cycle=%0d prev=%0d ack=%b err=%b data=%h want ack=1 err=0 data=%h spacing=3", c, last, bus.wb_ack, bus.wb_err, bus.wb_data, e.data);
        end
        last = c;
        pulses++;
      end
      bus.s_ack = bus.s_strobe;
      if (bus.s_strobe != 4'b0) begin
        bus.s_data[1] = 32'h0000_0100 + 32'(k);
        exp_q.push_back('{err: 1'b0, data: 32'h0000_0100 + 32'(k)});
        k++;
      end
    end
    drop();
    bus.wb_we = 1'b0;
    checks++;
    if (pulses != 3 || last != 8) begin
      failures++;
      $display("FAIL b2b_count got pulses=%0d last=%0d want pulses=3 last=8", pulses, last);
    end
    @(negedge clock);
    checks++;
    if ({bus.wb_ack, bus.wb_err} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_end got ack=%b err=%b want 0 0", bus.wb_ack, bus.wb_err);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_unmapped();
    test_timeout();
    test_stray_ack();
    test_abort_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
